// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and scoreboard entry type for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned IF_S     = 0;
  localparam int unsigned ID_S     = 1;
  localparam int unsigned EX_S     = 2;
  localparam int unsigned FWD_RF   = 0;
  // Widest register address the scoreboard entry can hold; narrower RA_W is zero-extended.
  localparam int unsigned RA_W_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard for stages EX..WB with a youngest-match encoder per source operand.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned FW_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  sb_entry_t            ex_entry,
  input  logic [1:0][RA_W-1:0] src,
  output logic [1:0]           hit_c,
  output logic [1:0]           load_hit_c,
  output logic [1:0][FW_W-1:0] code_c
);

  localparam int unsigned NENT   = NSTAGE - 2;
  localparam int unsigned NMATCH = NSTAGE - 3;

  sb_entry_t sb [NENT];

  // Stages at EX and beyond never stall, so the scoreboard shifts every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NENT); i++) sb[i] <= '0;
    end else begin
      sb[0] <= ex_entry;
      for (int i = 1; i < int'(NENT); i++) sb[i] <= sb[i-1];
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins; WB is excluded.
  always_comb begin
    hit_c      = '0;
    load_hit_c = '0;
    code_c     = '0;
    for (int j = 0; j < 2; j++) begin
      for (int e = int'(NMATCH) - 1; e >= 0; e--) begin
        if (sb[e].valid && sb[e].rd == RA_W_MAX'(src[j])) begin
          hit_c[j]      = 1'b1;
          load_hit_c[j] = sb[e].is_load && (e < int'(NMATCH) - 1);
          code_c[j]     = FW_W'(e + int'(EX_S) - 1);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: RAW hazard stalls, EX forward selects, branch flushes and perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned FW_W  = $clog2(NSTAGE - 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_regwrite,
  input  logic              id_memrd,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic [NSTAGE-2:0] stage_en,
  output logic [NSTAGE-2:0] stage_flush,
  output logic [FW_W-1:0]   fwd_a,
  output logic [FW_W-1:0]   fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [1:0]           used_c;
  logic [1:0]           hit_c;
  logic [1:0]           load_hit_c;
  logic [1:0][FW_W-1:0] code_c;
  logic                 raw_c;
  logic                 load_use_c;
  logic                 stall_c;
  logic                 advance_c;
  sb_entry_t            ex_entry_c;

  pipe_scoreboard #(
    .NSTAGE (NSTAGE),
    .RA_W   (RA_W),
    .FW_W   (FW_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_entry   (ex_entry_c),
    .src        ({id_rt, id_rs}),
    .hit_c      (hit_c),
    .load_hit_c (load_hit_c),
    .code_c     (code_c)
  );

  // Hazard decision; a taken branch overrides and discards any stall request.
  always_comb begin
    used_c     = {id_rt_used, id_rs_used};
    raw_c      = 1'b0;
    load_use_c = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (id_valid && used_c[j] && hit_c[j]) begin
        raw_c = 1'b1;
        if (load_hit_c[j]) load_use_c = 1'b1;
      end
    end
    stall_c   = (FWD_EN ? load_use_c : raw_c) && !ex_branch_taken;
    advance_c = !stall_c && !ex_branch_taken;

    ex_entry_c.valid   = advance_c && id_valid && id_regwrite && (id_rd != '0);
    ex_entry_c.rd      = RA_W_MAX'(id_rd);
    ex_entry_c.is_load = id_memrd;
  end

  // Enables and flushes follow the hazard decision in the same cycle; held off in reset.
  always_comb begin
    pc_en       = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    if (rst_n) begin
      pc_en    = !stall_c;
      stage_en = '1;
      if (stall_c) stage_en[IF_S] = 1'b0;
      if (ex_branch_taken) begin
        stage_flush[IF_S] = 1'b1;
        stage_flush[ID_S] = 1'b1;
      end else if (stall_c) begin
        stage_flush[ID_S] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (FWD_EN && advance_c && id_valid) begin
      fwd_a <= (id_rs_used && hit_c[0]) ? code_c[0] : FW_W'(FWD_RF);
      fwd_b <= (id_rt_used && hit_c[1]) ? code_c[1] : FW_W'(FWD_RF);
    end else begin
      fwd_a <= FW_W'(FWD_RF);
      fwd_b <= FW_W'(FWD_RF);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch priority, no-forward mode, saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_memrd, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        pc_en, pc_en0, pc_en4;
  logic [3:0]  stage_en, stage_en0, stage_en4;
  logic [3:0]  stage_flush, stage_flush0, stage_flush4;
  logic [1:0]  fwd_a, fwd_b, fwd_a0, fwd_b0, fwd_a4, fwd_b4;
  logic [15:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGE(5), .RA_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memrd(id_memrd), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .stage_en(stage_en), .stage_flush(stage_flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_ctrl #(.NSTAGE(5), .RA_W(5), .FWD_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memrd(id_memrd), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en0), .stage_en(stage_en0), .stage_flush(stage_flush0), .fwd_a(fwd_a0),
    .fwd_b(fwd_b0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  pipe_hazard_ctrl #(.NSTAGE(5), .RA_W(5), .FWD_EN(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memrd(id_memrd), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en4), .stage_en(stage_en4), .stage_flush(stage_flush4), .fwd_a(fwd_a4),
    .fwd_b(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rs_used  = rsu;
    id_rt       = rt;
    id_rt_used  = rtu;
    id_rd       = rd;
    id_regwrite = rw;
    id_memrd    = mr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    nop();
    repeat (2) cyc();
    #1;
    tests++;
    if ({pc_en, stage_en, stage_flush} !== 9'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got pc_en=%b en=%b fl=%b, expected all 0", pc_en, stage_en, stage_flush);
    end
    tests++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_regs: got fwd=%0d/%0d cnt=%0d/%0d, expected 0", fwd_a, fwd_b, stall_cnt, flush_cnt);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    tests++;
    if (pc_en !== 1'b1 || stage_en !== 4'b1111 || stage_flush !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release: got pc_en=%b en=%b fl=%b, expected 1/1111/0000", pc_en, stage_en, stage_flush);
    end
    cyc();
  endtask

  // FWD_EN=0: add r3 then a reader of r3 stalls two cycles.
  task automatic test_no_fwd();
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    tests++;
    if (pc_en0 !== 1'b0 || stage_flush0 !== 4'b0010 || stage_en0 !== 4'b1110) begin
      fails++;
      $display("FAIL nofwd_stall1: got pc_en=%b en=%b fl=%b, expected 0/1110/0010", pc_en0, stage_en0, stage_flush0);
    end
    cyc();
    #1;
    tests++;
    if (pc_en0 !== 1'b0) begin
      fails++;
      $display("FAIL nofwd_stall2: got pc_en=%b, expected 0", pc_en0);
    end
    cyc();
    #1;
    tests++;
    if (pc_en0 !== 1'b1) begin
      fails++;
      $display("FAIL nofwd_release: got pc_en=%b, expected 1", pc_en0);
    end
    cyc();
    tests++;
    if (fwd_a0 !== 2'd0 || fwd_b0 !== 2'd0 || stall_cnt0 !== 16'd2) begin
      fails++;
      $display("FAIL nofwd_result: got fwd=%0d/%0d stall_cnt=%0d, expected 0/0/2", fwd_a0, fwd_b0, stall_cnt0);
    end
  endtask

  // ALU producer forwarding: back-to-back gives code 1, one gap gives code 2.
  task automatic test_fwd_alu();
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    tests++;
    if (pc_en !== 1'b1 || stage_flush !== 4'b0000) begin
      fails++;
      $display("FAIL fwd_b2b_nostall: got pc_en=%b fl=%b, expected 1/0000", pc_en, stage_flush);
    end
    cyc();
    tests++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin
      fails++;
      $display("FAIL fwd_b2b: got fwd_a=%0d fwd_b=%0d, expected 1/0", fwd_a, fwd_b);
    end
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    nop();
    cyc();
    drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    cyc();
    tests++;
    if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      fails++;
      $display("FAIL fwd_gap: got fwd_a=%0d fwd_b=%0d, expected 2/0", fwd_a, fwd_b);
    end
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    cyc();
    tests++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd1) begin
      fails++;
      $display("FAIL fwd_rt: got fwd_a=%0d fwd_b=%0d, expected 0/1", fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    tests++;
    if (pc_en !== 1'b0 || stage_flush !== 4'b0010 || stage_en !== 4'b1110) begin
      fails++;
      $display("FAIL loaduse_stall: got pc_en=%b en=%b fl=%b, expected 0/1110/0010", pc_en, stage_en, stage_flush);
    end
    cyc();
    #1;
    tests++;
    if (stall_cnt !== 16'd1 || pc_en !== 1'b1) begin
      fails++;
      $display("FAIL loaduse_once: got stall_cnt=%0d pc_en=%b, expected 1/1", stall_cnt, pc_en);
    end
    cyc();
    tests++;
    if (fwd_a !== 2'd2 || stall_cnt !== 16'd1) begin
      fails++;
      $display("FAIL loaduse_fwd: got fwd_a=%0d stall_cnt=%0d, expected 2/1", fwd_a, stall_cnt);
    end
  endtask

  task automatic test_branch_stall();
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    tests++;
    if (stage_flush !== 4'b0011 || pc_en !== 1'b1 || stage_en !== 4'b1111) begin
      fails++;
      $display("FAIL branch_prio: got pc_en=%b en=%b fl=%b, expected 1/1111/0011", pc_en, stage_en, stage_flush);
    end
    cyc();
    ex_branch_taken = 1'b0;
    tests++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1 || fwd_a !== 2'd0) begin
      fails++;
      $display("FAIL branch_cnt: got stall_cnt=%0d flush_cnt=%0d fwd_a=%0d, expected 1/1/0", stall_cnt, flush_cnt, fwd_a);
    end
  endtask

  task automatic test_zero_rd();
    drain();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    tests++;
    if (pc_en !== 1'b1 || pc_en0 !== 1'b1) begin
      fails++;
      $display("FAIL zero_rd_stall: got pc_en=%b pc_en0=%b, expected 1/1", pc_en, pc_en0);
    end
    cyc();
    tests++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      fails++;
      $display("FAIL zero_rd_fwd: got fwd_a=%0d fwd_b=%0d, expected 0/0", fwd_a, fwd_b);
    end
  endtask

  // lw r4,(r4) repeated: stalls on every other cycle, 20 stalls in 40 cycles.
  task automatic test_saturate();
    drain();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    repeat (40) cyc();
    tests++;
    if (stall_cnt4 !== 4'hF) begin
      fails++;
      $display("FAIL cnt_saturate: got stall_cnt=%0d, expected 15", stall_cnt4);
    end
  endtask

  task automatic test_reset_midstream();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({pc_en, stage_en, stage_flush} !== 9'd0 || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      fails++;
      $display("FAIL midreset_low: got pc_en=%b en=%b fl=%b cnt=%0d cnt4=%0d, expected 0", pc_en, stage_en, stage_flush, stall_cnt, stall_cnt4);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    tests++;
    if (stage_en !== 4'b1111 || pc_en !== 1'b1) begin
      fails++;
      $display("FAIL midreset_release: got pc_en=%b en=%b, expected 1/1111", pc_en, stage_en);
    end
    cyc();
    tests++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      fails++;
      $display("FAIL midreset_cnt: got %0d/%0d/%0d, expected 0/0/0", stall_cnt, flush_cnt, stall_cnt4);
    end
  endtask

  initial begin
    test_reset();
    test_no_fwd();
    test_fwd_alu();
    test_load_use();
    test_branch_stall();
    test_zero_rd();
    test_saturate();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
